alu_result_serializer: RTL and testbench

- DUT-side transmitter for the ALU serial link: the end that drives `sout` toward the testbench.
- Accepts one ALU response per handshake: either a 32-bit result C with 4 flags, or an error indication.
- Serializes the response as 11-bit frames: DATA frames for C, then a CTL frame carrying flags and CRC3, or a single error CTL frame.
- Sits between the ALU core/result register and the `sout` pin.

---
 rtl/alu_result_serializer_if.sv | 27 ++
 rtl/alu_result_serializer.sv | 145 ++++++++++++++
 tb/tb_alu_result_serializer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_serializer_if.sv
// Response handshake and serial-line bundle for alu_result_serializer.
// Optional crc_corrupt member exists only when ALU_SERIALIZER_CRC_INJECT_EN is defined.
interface alu_result_serializer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] c;
    logic [3:0]  flags;
    logic        is_error;
    logic [2:0]  err_flags;
`ifdef ALU_SERIALIZER_CRC_INJECT_EN
    logic        crc_corrupt;
`endif
    logic        sout;
    logic        busy;

`ifdef ALU_SERIALIZER_CRC_INJECT_EN
    modport master (output in_valid, c, flags, is_error, err_flags, crc_corrupt,
                    input  in_ready, sout, busy);
    modport slave  (input  in_valid, c, flags, is_error, err_flags, crc_corrupt,
                    output in_ready, sout, busy);
`else
    modport master (output in_valid, c, flags, is_error, err_flags,
                    input  in_ready, sout, busy);
    modport slave  (input  in_valid, c, flags, is_error, err_flags,
                    output in_ready, sout, busy);
`endif
endinterface

// File: rtl/alu_result_serializer.sv
// Serial transmitter for ALU responses: 4 DATA frames + CRC3 CTL frame, or one error CTL frame.
// Optional macro ALU_SERIALIZER_CRC_INJECT_EN adds crc_corrupt to flip the sent crc[0].
module alu_result_serializer #(
    parameter int BIT_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    alu_result_serializer_if.slave    bus
);
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

    function automatic logic [2:0] crc3(input logic [36:0] v);
        logic [2:0] s;
        logic       fb;
        s = 3'b000;
        for (int i = 36; i >= 0; i--) begin
            fb = s[2] ^ v[i];
            s  = {s[1], s[0] ^ fb, fb};
        end
        return s;
    endfunction

    function automatic logic even_parity(input logic [6:0] v);
        return ^v;
    endfunction

    state_t          state_r;
    logic [39:0]     pkt_r;
    logic [2:0]      last_frame_r;
    logic [2:0]      frame_r;
    logic [3:0]      bit_r;
    logic [CW-1:0]   cyc_r;
    logic            sout_r;

    logic            accept_s;
    logic [2:0]      crc_s;
    logic [7:0]      result_ctl_s;
    logic [7:0]      error_ctl_s;
    logic [3:0]      bit_nxt_s;
    logic [7:0]      payload_s;
    logic            next_bit_s;

    // Acceptance and the CTL payloads built from the live inputs at the accepting edge
    always_comb begin
        accept_s = bus.in_valid && (state_r == IDLE);
`ifdef ALU_SERIALIZER_CRC_INJECT_EN
        crc_s = crc3({bus.c, 1'b0, bus.flags}) ^ {2'b00, bus.crc_corrupt};
`else
        crc_s = crc3({bus.c, 1'b0, bus.flags});
`endif
        result_ctl_s = {1'b0, bus.flags, crc_s};
        error_ctl_s  = {1'b1, bus.err_flags, bus.err_flags,
                        even_parity({1'b1, bus.err_flags, bus.err_flags})};
    end

    // Value of the next bit within the current frame (start/stop handled by the FSM)
    always_comb begin
        bit_nxt_s = bit_r + 4'd1;
        case (frame_r)
            3'd0:    payload_s = pkt_r[39:32];
            3'd1:    payload_s = pkt_r[31:24];
            3'd2:    payload_s = pkt_r[23:16];
            3'd3:    payload_s = pkt_r[15:8];
            3'd4:    payload_s = pkt_r[7:0];
            default: payload_s = 8'hFF;
        endcase
        case (bit_nxt_s)
            4'd1:    next_bit_s = (frame_r == last_frame_r);
            4'd10:   next_bit_s = 1'b1;
            default: begin
                if ((bit_nxt_s >= 4'd2) && (bit_nxt_s <= 4'd9)) begin
                    next_bit_s = payload_s[3'(4'd9 - bit_nxt_s)];
                end else begin
                    next_bit_s = 1'b1;
                end
            end
        endcase
    end

    // Packet FSM with frame/bit/cycle counters and the registered serial line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            pkt_r        <= 40'd0;
            last_frame_r <= 3'd0;
            frame_r      <= 3'd0;
            bit_r        <= 4'd0;
            cyc_r        <= '0;
            sout_r       <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r <= SEND;
                        frame_r <= 3'd0;
                        bit_r   <= 4'd0;
                        cyc_r   <= '0;
                        sout_r  <= 1'b0;
                        if (bus.is_error) begin
                            pkt_r        <= {error_ctl_s, 32'd0};
                            last_frame_r <= 3'd0;
                        end else begin
                            pkt_r        <= {bus.c, result_ctl_s};
                            last_frame_r <= 3'd4;
                        end
                    end else begin
                        sout_r <= 1'b1;
                    end
                end
                SEND: begin
                    if (cyc_r == CYC_LAST) begin
                        cyc_r <= '0;
                        if (bit_r == 4'd10) begin
                            bit_r <= 4'd0;
                            if (frame_r == last_frame_r) begin
                                state_r <= IDLE;
                                frame_r <= 3'd0;
                                sout_r  <= 1'b1;
                            end else begin
                                frame_r <= frame_r + 3'd1;
                                sout_r  <= 1'b0;
                            end
                        end else begin
                            bit_r  <= bit_nxt_s;
                            sout_r <= next_bit_s;
                        end
                    end else begin
                        cyc_r <= cyc_r + CW'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    sout_r  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.sout     = sout_r;
    assign bus.busy     = (state_r == SEND);
    assign bus.in_ready = (state_r == IDLE) && rst_n;
endmodule

// File: tb/tb_alu_result_serializer.sv
// Bench for alu_result_serializer: table of responses with hand-derived CTL payloads,
// scoreboarded serial streams, reset-mid-frame and BIT_CYCLES=4 back-to-back sequences.
module tb_alu_result_serializer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_result_serializer_if bus1();
    alu_result_serializer_if bus4();

    alu_result_serializer #(.BIT_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    alu_result_serializer #(.BIT_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    typedef struct {
        logic        is_err;
        logic [31:0] c;
        logic [3:0]  flags;
        logic [2:0]  errf;
        logic        corrupt;
        logic [7:0]  exp_ctl;
    } vec_t;

    typedef struct {
        logic [54:0] bits;
        int          len;
    } pkt_t;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    pkt_t sbq[$];

    function automatic vec_t mk(logic is_err, logic [31:0] c, logic [3:0] fl,
                                logic [2:0] ef, logic cor, logic [7:0] ctl);
        vec_t v;
        v.is_err = is_err; v.c = c; v.flags = fl; v.errf = ef; v.corrupt = cor; v.exp_ctl = ctl;
        return v;
    endfunction

    // Expected line sequence, first transmitted bit at bits[54]
    function automatic pkt_t expect_stream(vec_t v);
        pkt_t p;
        p.bits = '0;
        p.len  = 0;
        if (!v.is_err) begin
            for (int f = 0; f < 4; f++) begin
                p.bits[54 - p.len -: 11] = {1'b0, 1'b0, v.c[31 - 8*f -: 8], 1'b1};
                p.len += 11;
            end
        end
        p.bits[54 - p.len -: 11] = {1'b0, 1'b1, v.exp_ctl, 1'b1};
        p.len += 11;
        return p;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready1();
        int n = 0;
        while (!bus1.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("ready1_timeout", 64'(bus1.in_ready), 64'd1);
    endtask

    task automatic drive1(vec_t v);
        bus1.in_valid  = 1'b1;
        bus1.is_error  = v.is_err;
        bus1.c         = v.c;
        bus1.flags     = v.flags;
        bus1.err_flags = v.errf;
`ifdef ALU_SERIALIZER_CRC_INJECT_EN
        bus1.crc_corrupt = v.corrupt;
`endif
    endtask

    task automatic scramble1();
        bus1.in_valid  = 1'b0;
        bus1.is_error  = 1'($urandom);
        bus1.c         = $urandom;
        bus1.flags     = 4'($urandom);
        bus1.err_flags = 3'($urandom);
    endtask

    // Called at the negedge right after the accepting edge
    task automatic capture1(string name);
        pkt_t        e;
        logic [54:0] got;
        int          rdy_bad;
        int          busy_bad;
        e = sbq.pop_front();
        got = '0; rdy_bad = 0; busy_bad = 0;
        for (int k = 0; k < e.len; k++) begin
            got[54 - k] = bus1.sout;
            if (bus1.in_ready) rdy_bad++;
            if (!bus1.busy) busy_bad++;
            @(negedge clk);
        end
        check({name, "_stream"}, 64'(got), 64'(e.bits));
        check({name, "_ready_low"}, 64'(rdy_bad), 64'd0);
        check({name, "_busy_high"}, 64'(busy_bad), 64'd0);
        check({name, "_idle_after"}, 64'({bus1.sout, bus1.in_ready, bus1.busy}), 64'(3'b110));
    endtask

    task automatic send1(vec_t v, string name);
        wait_ready1();
        drive1(v);
        sbq.push_back(expect_stream(v));
        @(posedge clk);
        @(negedge clk);
        scramble1();
        capture1(name);
    endtask

    initial begin
        vec_t        vr;
        pkt_t        ea;
        pkt_t        eb;
        int          bad;
        int          rbad;
        int          idle_bad;
        logic        pre;

        vecs.push_back(mk(1'b0, 32'h1234_5678, 4'b0000, 3'b000, 1'b0, 8'h06));
        vecs.push_back(mk(1'b0, 32'h0000_0000, 4'b0010, 3'b000, 1'b0, 8'h16));
        vecs.push_back(mk(1'b1, 32'h0000_0000, 4'b0000, 3'b010, 1'b0, 8'hA5));
        vecs.push_back(mk(1'b0, 32'hFFFF_FFFF, 4'b1111, 3'b000, 1'b0, 8'h7C));
        vecs.push_back(mk(1'b0, 32'h8000_0001, 4'b0001, 3'b000, 1'b0, 8'h0F));
        vecs.push_back(mk(1'b1, 32'hDEAD_BEEF, 4'b1010, 3'b101, 1'b0, 8'hDB));
        vecs.push_back(mk(1'b1, 32'h1234_5678, 4'b0000, 3'b111, 1'b0, 8'hFF));
        vecs.push_back(mk(1'b1, 32'hFFFF_FFFF, 4'b1111, 3'b000, 1'b0, 8'h81));
`ifdef ALU_SERIALIZER_CRC_INJECT_EN
        vecs.push_back(mk(1'b0, 32'h1234_5678, 4'b0000, 3'b000, 1'b1, 8'h07));
        vecs.push_back(mk(1'b1, 32'h0000_0000, 4'b0000, 3'b010, 1'b1, 8'hA5));
        bus1.crc_corrupt = 1'b0;
        bus4.crc_corrupt = 1'b0;
`endif

        rst_n = 1'b0;
        bus1.in_valid = 1'b0; bus1.is_error = 1'b0; bus1.c = 32'd0; bus1.flags = 4'd0; bus1.err_flags = 3'd0;
        bus4.in_valid = 1'b0; bus4.is_error = 1'b0; bus4.c = 32'd0; bus4.flags = 4'd0; bus4.err_flags = 3'd0;
        @(negedge clk);
        check("reset_outputs1", 64'({bus1.sout, bus1.busy, bus1.in_ready}), 64'(3'b100));
        check("reset_outputs4", 64'({bus4.sout, bus4.busy, bus4.in_ready}), 64'(3'b100));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        idle_bad = 0;
        for (int i = 0; i < 100; i++) begin
            if ({bus1.sout, bus1.busy, bus1.in_ready} !== 3'b101) idle_bad++;
            @(negedge clk);
        end
        check("idle_100", 64'(idle_bad), 64'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            send1(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset asserted during frame 2, bit 5 (sample index 27) of a result packet
        vr = mk(1'b0, 32'hA5A5_A5A5, 4'b0101, 3'b000, 1'b0, 8'h00);
        ea = expect_stream(vr);
        wait_ready1();
        drive1(vr);
        @(posedge clk);
        @(negedge clk);
        scramble1();
        repeat (27) @(negedge clk);
        pre = bus1.sout;
        check("pre_reset_bit", 64'(pre), 64'(ea.bits[54 - 27]));
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_line", 64'({bus1.sout, bus1.busy, bus1.in_ready}), 64'(3'b100));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        idle_bad = 0;
        for (int i = 0; i < 40; i++) begin
            if ({bus1.sout, bus1.busy, bus1.in_ready} !== 3'b101) idle_bad++;
            @(negedge clk);
        end
        check("no_residual_bits", 64'(idle_bad), 64'd0);
        send1(vecs[1], "after_reset");

        // BIT_CYCLES=4, in_valid held high across two packets
        ea = expect_stream(vecs[0]);
        eb = expect_stream(vecs[4]);
        begin : bc4
            int n = 0;
            while (!bus4.in_ready && n < 300) begin
                @(negedge clk);
                n++;
            end
            check("ready4_timeout", 64'(bus4.in_ready), 64'd1);
        end
        bus4.in_valid = 1'b1;
        bus4.is_error = 1'b0;
        bus4.c = vecs[0].c;
        bus4.flags = vecs[0].flags;
        @(posedge clk);
        @(negedge clk);
        bus4.c = vecs[4].c;
        bus4.flags = vecs[4].flags;
        bad = 0; rbad = 0;
        for (int k = 0; k < 220; k++) begin
            if (bus4.sout !== ea.bits[54 - k/4]) bad++;
            if (bus4.in_ready || !bus4.busy) rbad++;
            @(negedge clk);
        end
        check("bc4_pkt_a_stream", 64'(bad), 64'd0);
        check("bc4_pkt_a_ready_busy", 64'(rbad), 64'd0);
        check("bc4_gap_idle", 64'({bus4.sout, bus4.in_ready, bus4.busy}), 64'(3'b110));
        @(negedge clk);
        bus4.in_valid = 1'b0;
        bad = 0; rbad = 0;
        for (int k = 0; k < 220; k++) begin
            if (bus4.sout !== eb.bits[54 - k/4]) bad++;
            if (bus4.in_ready || !bus4.busy) rbad++;
            @(negedge clk);
        end
        check("bc4_pkt_b_stream", 64'(bad), 64'd0);
        check("bc4_pkt_b_ready_busy", 64'(rbad), 64'd0);
        check("bc4_idle_after", 64'({bus4.sout, bus4.in_ready, bus4.busy}), 64'(3'b110));
        repeat (3) @(negedge clk);
        check("bc4_stays_idle", 64'({bus4.sout, bus4.in_ready, bus4.busy}), 64'(3'b110));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
